// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: FSM state encoding
// and the default operand width.
package div_pkg;

  localparam int DIV_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift {rem,quo} left by one, trial-subtract the
// divisor and shift the resulting quotient bit into the LSB.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEF
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_out,
  output logic [WIDTH-1:0] quo_out
);

  logic [WIDTH:0] shifted;
  logic           fits;
  // The partial remainder always stays below the divisor, so its MSB is zero.
  logic           unused_rem_msb;

  assign unused_rem_msb = rem_in[WIDTH];

  always_comb begin
    shifted = {rem_in[WIDTH-1:0], quo_in[WIDTH-1]};
    fits    = (shifted >= {1'b0, divisor});
    rem_out = fits ? (shifted - {1'b0, divisor}) : shifted;
    quo_out = {quo_in[WIDTH-2:0], fits};
  end

endmodule

// File: rtl/seq_div_8bit.sv
// Sequential unsigned restoring divider, one quotient bit per clock, with
// valid/ready handshakes. Optional macro DIV_ZERO_ERR_EN adds a fast
// divide-by-zero path and the div_zero flag.
module seq_div_8bit
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
`ifdef DIV_ZERO_ERR_EN
  ,
  output logic             div_zero
`endif
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  div_state_e       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] quo_sr;
  logic [WIDTH:0]   rem_sr;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] quo_n;
  logic [WIDTH:0]   rem_n;
  logic             accept;

  assign accept = (state == IDLE) && in_valid;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_sr),
    .quo_in  (quo_sr),
    .divisor (dvs),
    .rem_out (rem_n),
    .quo_out (quo_n)
  );

  // NOTE: the working registers are not reset; they are always loaded on
  // acceptance before being read, so a reset term would only add logic.
  always_ff @(posedge clk) begin
    if (accept) begin
      quo_sr <= dividend;
      rem_sr <= '0;
      dvs    <= divisor;
    end else if (state == BUSY) begin
      quo_sr <= quo_n;
      rem_sr <= rem_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
`ifdef DIV_ZERO_ERR_EN
      div_zero  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
`ifdef DIV_ZERO_ERR_EN
            if (divisor == '0) begin
              // Result is known immediately; out_valid rises one edge later.
              state     <= DONE;
              quotient  <= '1;
              remainder <= dividend;
              div_zero  <= 1'b1;
            end else begin
              state <= BUSY;
              cnt   <= CW'(WIDTH - 1);
            end
`else
            state <= BUSY;
            cnt   <= CW'(WIDTH - 1);
`endif
          end
        end
        BUSY: begin
          if (cnt == '0) begin
            state     <= DONE;
            out_valid <= 1'b1;
            quotient  <= quo_n;
            remainder <= rem_n[WIDTH-1:0];
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
`ifdef DIV_ZERO_ERR_EN
            div_zero  <= 1'b0;
`endif
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_div_8bit.sv
// Self-checking bench for seq_div_8bit: directed cases plus a random sweep,
// with a queue scoreboard fed at acceptance and drained at each result.
module tb_seq_div_8bit;
  import div_pkg::*;

  localparam int W       = DIV_WIDTH_DEF;
  localparam int TIMEOUT = 200;
  localparam int N_RAND  = 2000;
`ifdef DIV_ZERO_ERR_EN
  localparam int ZERO_LAT = 1;
`else
  localparam int ZERO_LAT = W;
`endif

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
`ifdef DIV_ZERO_ERR_EN
  logic         div_zero;
`endif

  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;

  seq_div_8bit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder)
`ifdef DIV_ZERO_ERR_EN
    ,
    .div_zero  (div_zero)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, passed=%0d total=%0d", passed, total);
    $fatal(1, "watchdog");
  end

  function automatic exp_t ref_div(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    if (b == '0) begin
      e.q = '1;
      e.r = a;
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one operand pair, wait for it to be taken, record the expectation.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    int n = 0;
    while (in_ready !== 1'b1 && n < TIMEOUT) begin
      tick();
      n++;
    end
    if (n >= TIMEOUT) begin
      total++;
      $display("FAIL issue_ready_timeout: in_ready=%b, required 1 within %0d cycles", in_ready, TIMEOUT);
    end
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    tick();
    in_valid = 1'b0;
    dividend = W'($urandom);
    divisor  = W'($urandom);
    sb.push_back(ref_div(a, b));
  endtask

  // Count edges from the accepting edge until out_valid is seen.
  task automatic wait_out(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < TIMEOUT) begin
      tick();
      lat++;
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    total++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b, required 1", in_ready);
    else passed++;
    total++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b, required 0", out_valid);
    else passed++;
    total++;
    if (quotient !== '0 || remainder !== '0)
      $display("FAIL reset_outputs: got q=%0d r=%0d, required q=0 r=0", quotient, remainder);
    else passed++;
`ifdef DIV_ZERO_ERR_EN
    total++;
    if (div_zero !== 1'b0) $display("FAIL reset_div_zero: got %b, required 0", div_zero);
    else passed++;
`endif
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int   lat;
    exp_t e;
    out_ready = 1'b1;
    issue(8'd100, 8'd7);
    wait_out(lat);
    e = sb.pop_front();
    total++;
    if (lat != W) $display("FAIL basic_latency: got %0d edges, required %0d", lat, W);
    else passed++;
    total++;
    if (quotient !== e.q || remainder !== e.r)
      $display("FAIL basic_100_7: got q=%0d r=%0d, required q=%0d r=%0d", quotient, remainder, e.q, e.r);
    else passed++;
    handshake();
  endtask

  task automatic test_corners();
    logic [W-1:0] as [4];
    logic [W-1:0] bs [4];
    int   lat;
    exp_t e;
    as = '{8'd255, 8'd5, 8'd255, 8'd0};
    bs = '{8'd1,   8'd9, 8'd255, 8'd13};
    for (int i = 0; i < 4; i++) begin
      issue(as[i], bs[i]);
      wait_out(lat);
      e = sb.pop_front();
      total++;
      if (lat != W || quotient !== e.q || remainder !== e.r)
        $display("FAIL corner_%0d_%0d: got q=%0d r=%0d lat=%0d, required q=%0d r=%0d lat=%0d",
                 as[i], bs[i], quotient, remainder, lat, e.q, e.r, W);
      else passed++;
      handshake();
    end
  endtask

  task automatic test_div_zero();
    int   lat;
    exp_t e;
    issue(8'd37, 8'd0);
    wait_out(lat);
    e = sb.pop_front();
    total++;
    if (lat != ZERO_LAT) $display("FAIL zero_latency: got %0d edges, required %0d", lat, ZERO_LAT);
    else passed++;
    total++;
    if (quotient !== e.q || remainder !== e.r)
      $display("FAIL zero_result: got q=%0d r=%0d, required q=%0d r=%0d", quotient, remainder, e.q, e.r);
    else passed++;
`ifdef DIV_ZERO_ERR_EN
    total++;
    if (div_zero !== 1'b1) $display("FAIL zero_flag: got %b, required 1", div_zero);
    else passed++;
`endif
    handshake();
  endtask

  task automatic test_stall();
    int           lat;
    exp_t         e;
    logic [W-1:0] q0;
    logic [W-1:0] r0;
    out_ready = 1'b0;
    issue(8'd77, 8'd5);
    wait_out(lat);
    q0 = quotient;
    r0 = remainder;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || quotient !== q0 || remainder !== r0)
        $display("FAIL stall_hold_%0d: got v=%b rdy=%b q=%0d r=%0d, required v=1 rdy=0 q=%0d r=%0d",
                 i, out_valid, in_ready, quotient, remainder, q0, r0);
      else passed++;
    end
    e = sb.pop_front();
    total++;
    if (q0 !== e.q || r0 !== e.r)
      $display("FAIL stall_result: got q=%0d r=%0d, required q=%0d r=%0d", q0, r0, e.q, e.r);
    else passed++;
    // A new pair offered on the releasing edge must not be taken.
    in_valid = 1'b1;
    dividend = 8'd9;
    divisor  = 8'd2;
    handshake();
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL stall_release: got v=%b rdy=%b, required v=0 rdy=1", out_valid, in_ready);
    else passed++;
  endtask

  task automatic test_reset_mid_busy();
    int   lat;
    exp_t e;
    exp_t dropped;
    out_ready = 1'b1;
    issue(8'd100, 8'd7);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    dropped = sb.pop_back();
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || quotient !== '0 || remainder !== '0)
      $display("FAIL midrst_state: got v=%b rdy=%b q=%0d r=%0d (dropped q=%0d), required v=0 rdy=1 q=0 r=0",
               out_valid, in_ready, quotient, remainder, dropped.q);
    else passed++;
    rst      = 1'b0;
    in_valid = 1'b1;
    dividend = 8'd200;
    divisor  = 8'd3;
    tick();
    in_valid = 1'b0;
    sb.push_back(ref_div(8'd200, 8'd3));
    total++;
    if (in_ready !== 1'b0) $display("FAIL midrst_accept: got in_ready=%b, required 0", in_ready);
    else passed++;
    wait_out(lat);
    e = sb.pop_front();
    total++;
    if (lat != W || quotient !== e.q || remainder !== e.r)
      $display("FAIL midrst_200_3: got q=%0d r=%0d lat=%0d, required q=%0d r=%0d lat=%0d",
               quotient, remainder, lat, e.q, e.r, W);
    else passed++;
    handshake();
  endtask

  task automatic test_random();
    int           lat;
    int           stall;
    int           exp_lat;
    exp_t         e;
    logic [W-1:0] a;
    logic [W-1:0] b;
    for (int i = 0; i < N_RAND; i++) begin
      a = W'($urandom);
      b = ($urandom_range(0, 15) == 0) ? '0 : W'($urandom);
      exp_lat = (b == '0) ? ZERO_LAT : W;
      out_ready = 1'($urandom_range(0, 1));
      issue(a, b);
      wait_out(lat);
      stall = $urandom_range(0, 3);
      if (stall > 0) begin
        out_ready = 1'b0;
        repeat (stall) tick();
      end
      e = sb.pop_front();
      total++;
      if (lat != exp_lat || out_valid !== 1'b1 || quotient !== e.q || remainder !== e.r)
        $display("FAIL random_%0d (%0d/%0d): got q=%0d r=%0d lat=%0d v=%b, required q=%0d r=%0d lat=%0d v=1",
                 i, a, b, quotient, remainder, lat, out_valid, e.q, e.r, exp_lat);
      else passed++;
      handshake();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_div_zero();
    test_stall();
    test_reset_mid_busy();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
